upsizing_arbiter: RTL and testbench



---
 rtl/upsizing_arbiter_pkg.sv | 11 +
 rtl/upsizing_arbiter_rr_pick.sv | 25 ++
 rtl/upsizing_arbiter.sv | 80 ++++++++
 tb/tb_upsizing_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upsizing_arbiter_pkg.sv
// Shared types and defaults for the round-robin arbiter that feeds the 2W upsizer.
package upsizing_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int DEFAULT_W = 40;

endpackage

// File: rtl/upsizing_arbiter_rr_pick.sv
// Rotating-priority selector: returns the active requester closest to ptr,
// walking ptr, ptr+1, ... modulo N.
module rr_pick #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] index
);

   // Scan from the farthest distance inward so the nearest hit is the last write.
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            found = 1'b1;
            index = IW'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/upsizing_arbiter.sv
// N-way round-robin arbiter that locks each grant for BURST narrow beats so
// the downstream 2W upsizer never pairs beats from two different requesters.
module upsizing_arbiter
   import upsizing_arb_pkg::*;
#(
   parameter  int W     = DEFAULT_W,
   parameter  int N     = 4,
   parameter  int BURST = 2,
   localparam int IW    = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N*W-1:0] in_tdata,
   input  logic [N-1:0]   in_tvalid,
   output logic [N-1:0]   in_tready,
   output logic [W-1:0]   out_tdata,
   output logic           out_tvalid,
   input  logic           out_tready,
   output logic [IW-1:0]  out_tid
);

   localparam int CW = $clog2(BURST + 1);

   state_t        state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] grant;
   logic [CW-1:0] beat_cnt;
   logic          pick_found;
   logic [IW-1:0] pick_index;
   logic          locked;
   logic          accept;

   rr_pick #(.N(N)) u_rr_pick (
      .req   (in_tvalid),
      .ptr   (ptr),
      .found (pick_found),
      .index (pick_index)
   );

   // The granted requester is muxed straight through; IDLE masks valid and ready.
   assign locked     = (state == LOCKED);
   assign out_tid    = grant;
   assign out_tvalid = locked && in_tvalid[grant];
   assign out_tdata  = in_tdata[grant*W +: W];
   assign in_tready  = locked ? (N'(out_tready) << grant) : '0;
   assign accept     = out_tvalid && out_tready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         grant    <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant    <= pick_index;
                  beat_cnt <= '0;
                  state    <= LOCKED;
               end
            end
            LOCKED: begin
               // The grant is only released after a full burst, never on a valid drop.
               if (accept) begin
                  if (beat_cnt == CW'(BURST - 1)) begin
                     state    <= IDLE;
                     ptr      <= (grant == IW'(N - 1)) ? '0 : grant + 1'b1;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_upsizing_arbiter.sv
// Scoreboard bench: stimulus queues per requester, expected 2W words queued in
// grant order, and a monitor that pairs accepted beats the way the upsizer does.
module tb_upsizing_arbiter;
   import upsizing_arb_pkg::*;

   localparam int W     = 40;
   localparam int N     = 4;
   localparam int BURST = 2;
   localparam int IW    = $clog2(N);
   localparam int WW    = 2 * W;

   typedef struct packed {
      logic [W-1:0] data;
      logic [7:0]   gap;
   } beat_t;

   typedef struct packed {
      logic [WW-1:0] word;
      logic [IW-1:0] tid;
   } exp_t;

   logic           clk;
   logic           rst;
   logic [N*W-1:0] in_tdata;
   logic [N-1:0]   in_tvalid;
   logic [N-1:0]   in_tready;
   logic [W-1:0]   out_tdata;
   logic           out_tvalid;
   logic           out_tready;
   logic [IW-1:0]  out_tid;

   beat_t         src_q [N][$];
   exp_t          exp_q [$];
   logic [N-1:0]  hs;
   logic          loaded [N];
   int            gap_left [N];
   int            grants [N];
   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   int            first_accept_cyc = -1;
   int            beats_seen = 0;
   int            ready_mode = 0;
   int            rand_left = 0;
   logic          have_half;
   logic [W-1:0]  half_data;
   logic [IW-1:0] half_tid;

   upsizing_arbiter #(.W(W), .N(N), .BURST(BURST)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_tdata   (in_tdata),
      .in_tvalid  (in_tvalid),
      .in_tready  (in_tready),
      .out_tdata  (out_tdata),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready),
      .out_tid    (out_tid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic check_output(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic check_word(input logic [WW-1:0] word, input logic [IW-1:0] tid0, input logic [IW-1:0] tid1);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL unexpected_word: got %h required no word", word);
      end else begin
         e = exp_q.pop_front();
         check_output("word", word, e.word);
         check_output("tid_first_beat", WW'(tid0), WW'(e.tid));
         check_output("tid_second_beat", WW'(tid1), WW'(e.tid));
         grants[tid0]++;
      end
   endtask

   // Upsizer model: pairs accepted beats into 2W words, dropping a half word on reset.
   initial begin
      have_half = 1'b0;
      half_data = '0;
      half_tid  = '0;
      forever begin
         @(negedge clk);
         hs = in_tvalid & in_tready;
         if (rst) begin
            have_half = 1'b0;
         end else if (out_tvalid && out_tready) begin
            beats_seen++;
            if (first_accept_cyc < 0) first_accept_cyc = cyc;
            if (!have_half) begin
               half_data = out_tdata;
               half_tid  = out_tid;
               have_half = 1'b1;
            end else begin
               have_half = 1'b0;
               check_word({half_data, out_tdata}, half_tid, out_tid);
            end
         end
      end
   end

   // Requester and sink driver: updates inputs 1 time unit after each rising edge.
   initial begin
      in_tvalid  = '0;
      in_tdata   = '0;
      out_tready = 1'b1;
      for (int i = 0; i < N; i++) begin
         loaded[i]   = 1'b0;
         gap_left[i] = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (hs[i] && src_q[i].size() > 0) begin
               void'(src_q[i].pop_front());
               loaded[i] = 1'b0;
            end
            if (src_q[i].size() == 0) begin
               in_tvalid[i] = 1'b0;
            end else begin
               if (!loaded[i]) begin
                  gap_left[i] = int'(src_q[i][0].gap);
                  loaded[i]   = 1'b1;
               end
               if (gap_left[i] > 0) begin
                  gap_left[i]--;
                  in_tvalid[i] = 1'b0;
               end else begin
                  in_tvalid[i]        = 1'b1;
                  in_tdata[i*W +: W]  = src_q[i][0].data;
               end
            end
         end
         case (ready_mode)
            1: out_tready = ~out_tready;
            2: begin
               if (rand_left > 0) begin
                  out_tready = 1'($urandom_range(0, 1));
                  rand_left--;
               end else begin
                  out_tready = 1'b1;
               end
            end
            default: out_tready = 1'b1;
         endcase
      end
   end

   task automatic apply_stimulus(input int i, input logic [W-1:0] data, input int gap);
      beat_t b;
      b.data = data;
      b.gap  = 8'(gap);
      src_q[i].push_back(b);
   endtask

   task automatic expect_word(input logic [WW-1:0] word, input int tid);
      exp_t e;
      e.word = word;
      e.tid  = IW'(tid);
      exp_q.push_back(e);
   endtask

   task automatic sync_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic flush_sources();
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         loaded[i] = 1'b0;
      end
   endtask

   task automatic apply_reset();
      sync_edge();
      rst = 1'b1;
      ready_mode = 0;
      flush_sources();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   function automatic int queued_beats();
      int n = 0;
      for (int i = 0; i < N; i++) n += src_q[i].size();
      return n;
   endfunction

   function automatic bit drained();
      return (exp_q.size() == 0) && !have_half && (queued_beats() == 0);
   endfunction

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (!drained() && n < budget) begin
         @(posedge clk);
         n++;
      end
      #2;
      checks++;
      if (!drained()) begin
         errors++;
         $display("[TB] FAIL %s_drain: got %0d words and %0d beats outstanding required 0",
                  name, exp_q.size(), queued_beats());
      end
   endtask

   initial begin
      repeat (30000) @(posedge clk);
      $display("[TB] FAIL watchdog: got no finish within 30000 cycles required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int push_cyc;
      int b0;
      int n;
      logic [W-1:0] d0;
      logic [W-1:0] d1;

      rst = 1'b1;
      for (int i = 0; i < N; i++) grants[i] = 0;
      repeat (3) @(posedge clk);
      #2;
      check_output("reset_out_tvalid", WW'(out_tvalid), '0);
      check_output("reset_in_tready", WW'(in_tready), '0);
      check_output("reset_out_tid", WW'(out_tid), '0);
      rst = 1'b0;

      $display("[TB] single requester, one bubble before first beat");
      apply_reset();
      sync_edge();
      first_accept_cyc = -1;
      push_cyc = cyc;
      apply_stimulus(0, "ABCDE", 0);
      apply_stimulus(0, "FGHIJ", 0);
      expect_word("ABCDEFGHIJ", 0);
      wait_drain("single", 100);
      check_output("first_beat_latency", WW'(first_accept_cyc), WW'(push_cyc + 2));

      $display("[TB] two requesters from reset pointer");
      apply_reset();
      sync_edge();
      apply_stimulus(0, "ABCDE", 0);
      apply_stimulus(0, "FGHIJ", 0);
      apply_stimulus(1, "KLMON", 0);
      apply_stimulus(1, "PQRST", 0);
      expect_word("ABCDEFGHIJ", 0);
      expect_word("KLMONPQRST", 1);
      wait_drain("two_req", 100);

      // The pointer left at 2 by the previous pair makes requester 2 win over 0.
      $display("[TB] granted requester drops valid mid-burst");
      sync_edge();
      apply_stimulus(2, "UVWXY", 0);
      apply_stimulus(2, "Z0123", 3);
      apply_stimulus(0, "abcde", 0);
      apply_stimulus(0, "fghij", 0);
      expect_word("UVWXYZ0123", 2);
      expect_word("abcdefghij", 0);
      wait_drain("valid_drop", 100);

      $display("[TB] all requesters busy for 4N bursts");
      apply_reset();
      sync_edge();
      for (int i = 0; i < N; i++) grants[i] = 0;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < N; i++) begin
            d0 = {8'h52, 8'(i), 8'(k), 8'h00, 8'h2E};
            d1 = {8'h52, 8'(i), 8'(k), 8'h01, 8'h2E};
            apply_stimulus(i, d0, 0);
            apply_stimulus(i, d1, 0);
            expect_word({d0, d1}, i);
         end
      end
      wait_drain("all_busy", 400);
      for (int i = 0; i < N; i++) check_output("grant_count", WW'(grants[i]), WW'(4));

      $display("[TB] toggling downstream ready");
      apply_reset();
      ready_mode = 1;
      sync_edge();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 2; i++) begin
            d0 = {8'h54, 8'(i), 8'(k), 8'h00, 8'h2E};
            d1 = {8'h54, 8'(i), 8'(k), 8'h01, 8'h2E};
            apply_stimulus(i, d0, 0);
            apply_stimulus(i, d1, 0);
            expect_word({d0, d1}, i);
         end
      end
      wait_drain("toggle_ready", 1000);

      $display("[TB] random downstream ready");
      apply_reset();
      rand_left  = 50;
      ready_mode = 2;
      sync_edge();
      for (int k = 0; k < 2; k++) begin
         for (int i = 2; i < 4; i++) begin
            d0 = {8'h58, 8'(i), 8'(k), 8'h00, 8'h2E};
            d1 = {8'h58, 8'(i), 8'(k), 8'h01, 8'h2E};
            apply_stimulus(i, d0, 0);
            apply_stimulus(i, d1, 0);
            expect_word({d0, d1}, i);
         end
      end
      wait_drain("random_ready", 1000);

      $display("[TB] reset in the middle of a burst");
      apply_reset();
      sync_edge();
      b0 = beats_seen;
      apply_stimulus(1, "xxxxx", 0);
      apply_stimulus(1, "yyyyy", 0);
      n = 0;
      while (beats_seen == b0 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_output("first_beat_seen", WW'(beats_seen - b0), WW'(1));
      @(posedge clk);
      #2;
      rst = 1'b1;
      flush_sources();
      #1;
      check_output("midreset_out_tvalid", WW'(out_tvalid), '0);
      check_output("midreset_in_tready", WW'(in_tready), '0);
      check_output("midreset_out_tid", WW'(out_tid), '0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      sync_edge();
      apply_stimulus(1, "KLMON", 0);
      apply_stimulus(1, "PQRST", 0);
      apply_stimulus(0, "ABCDE", 0);
      apply_stimulus(0, "FGHIJ", 0);
      expect_word("ABCDEFGHIJ", 0);
      expect_word("KLMONPQRST", 1);
      wait_drain("after_reset", 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
